csa_accumulator: RTL and testbench

Parametrised multi-operand carry-save accumulator for the Montgomery multiplier datapath. It accepts a stream of WIDTH-bit operands, each added or subtracted, and keeps the running total in redundant sum/carry form at one operand per cycle. On the last operand it resolves the redundant pair to binary with a chunked carry-propagate adder, CHUNK bits per cycle. It then presents the AW-bit two's-complement result over a valid/ready handshake.

---
 rtl/csa_acc_pkg.sv | 17 +
 rtl/csa_row_3to2.sv | 16 +
 rtl/csa_accumulator.sv | 121 ++++++++++++
 tb/tb_csa_accumulator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
// Default widths match the Montgomery multiplier top.
package csa_acc_pkg;
  localparam int DEF_WIDTH = 256;
  localparam int DEF_GUARD = 8;
  localparam int DEF_CHUNK = 64;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  function automatic int calc_nch(input int aw, input int chunk);
    return (aw + chunk - 1) / chunk;
  endfunction
endpackage

// File: rtl/csa_row_3to2.sv
// One row of full adders: compresses three N-bit vectors into sum and carry.
// cout is pre-shifted so it lines up with s; cout[0] is always 0.
module csa_row_3to2
  import csa_acc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] cin,
  output logic [N-1:0] s,
  output logic [N:0]   cout
);
  assign s    = a ^ b ^ cin;
  assign cout = {(a & b) | (a & cin) | (b & cin), 1'b0};
endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand add/subtract accumulator kept in carry-save form, resolved to
// binary by a CHUNK-bit-per-cycle carry-propagate adder, then handed out.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GUARD = DEF_GUARD,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_neg,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+GUARD-1:0] out_data
);
  localparam int AW  = WIDTH + GUARD;
  localparam int NCH = calc_nch(AW, CHUNK);
  localparam int PW  = NCH * CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   s_q, s_d, c_q, c_d, out_q, out_d;
  logic [PW-1:0]   res_q, res_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;

  logic [AW-1:0]   x, row_s;
  logic [AW:0]     row_c;
  logic [PW-1:0]   s_pad, c_pad;
  logic [CHUNK:0]  chunk_sum;
  logic            unused_row;

  // Subtraction adds ~x here; the matching +1 goes into the free carry LSB.
  assign x = in_neg ? ~AW'(in_data) : AW'(in_data);

  csa_row_3to2 #(.N(AW)) u_row (
    .a    (s_q),
    .b    (c_q),
    .cin  (x),
    .s    (row_s),
    .cout (row_c)
  );
  assign unused_row = row_c[AW] ^ row_c[0];

  assign s_pad     = PW'(s_q);
  assign c_pad     = PW'(c_q);
  assign chunk_sum = {1'b0, s_pad[int'(idx_q)*CHUNK +: CHUNK]}
                   + {1'b0, c_pad[int'(idx_q)*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(cy_q);

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    res_d   = res_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    out_d   = out_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          s_d = row_s;
          c_d = {row_c[AW-1:1], in_neg};
          if (in_last) begin
            state_d = ST_RESOLVE;
            idx_d   = '0;
            cy_d    = 1'b0;
          end
        end
      end
      ST_RESOLVE: begin
        res_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        cy_d = chunk_sum[CHUNK];
        if (idx_q == IW'(NCH-1)) begin
          out_d   = res_d[AW-1:0];
          idx_d   = '0;
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_csa_accumulator.sv
// Randomized and directed checks of csa_accumulator against a plain-arithmetic
// model of the running total and handshake timing.
`timescale 1ns/1ps
module tb_csa_accumulator;
  localparam int W   = 256;
  localparam int AW  = 264;
  localparam int NCH = 5;

  logic          clk = 0, rst = 1;
  logic          in_valid = 0, in_neg = 0, in_last = 0, out_ready = 0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid;
  logic [AW-1:0] out_data;

  int errors = 0, checks = 0;

  csa_accumulator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: phase 0 accumulate, 1 resolving, 2 holding the result.
  int            ph, cnt;
  logic [AW-1:0] macc, mout;

  function automatic logic [AW-1:0] opval(input logic [W-1:0] d, input logic neg);
    return neg ? (AW'(0) - AW'(d)) : AW'(d);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0; cnt <= 0; macc <= '0; mout <= '0;
    end else begin
      case (ph)
        0: if (in_valid) begin
             macc <= macc + opval(in_data, in_neg);
             if (in_last) begin ph <= 1; cnt <= NCH; end
           end
        1: begin
             if (cnt == 1) begin ph <= 2; mout <= macc; end
             cnt <= cnt - 1;
           end
        default: if (out_ready) begin ph <= 0; macc <= '0; end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    chk("in_ready", AW'(in_ready), AW'(ph == 0));
    chk("out_valid", AW'(out_valid), AW'(ph == 2));
    chk("out_data", out_data, mout);
  end

  task automatic send(input logic [W-1:0] d, input logic neg, input logic last);
    int n = 0;
    bit ok = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      in_valid = 1; in_data = d; in_neg = neg; in_last = last;
      ok = in_ready;
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; in_neg = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic collect(input logic [AW-1:0] exp, input string nm, input bit rnd);
    int n = 0;
    bit done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk(nm, out_data, exp);
        done = 1;
      end
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no result expected %h", nm, exp);
    end
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    int n;
    logic [AW-1:0] exp;
    logic [W-1:0] d;
    logic neg;
    #12;
    chk("rst_in_ready", AW'(in_ready), AW'(1));
    chk("rst_out_valid", AW'(out_valid), AW'(0));
    chk("rst_out_data", out_data, '0);
    @(negedge clk); rst = 0;

    // single operand and latency
    send(W'(16'h1234), 0, 1);
    wait_valid(n);
    chk("latency", AW'(n), AW'(NCH));
    collect(AW'(16'h1234), "single", 0);

    // three maximal operands back-to-back
    d = '1;
    send(d, 0, 0); send(d, 0, 0); send(d, 0, 1);
    collect({8'h02, {63{4'hF}}, 4'hD}, "three_max", 0);

    // +5 -7
    send(W'(5), 0, 0); send(W'(7), 1, 1);
    collect({{263{1'b1}}, 1'b0}, "five_minus_seven", 0);

    // +1 -1, carry ripples across every chunk
    send(W'(1), 0, 0); send(W'(1), 1, 1);
    collect('0, "one_minus_one", 0);

    // output stall with pending input
    send(W'(8'h55), 0, 1);
    wait_valid(n);
    @(negedge clk);
    in_valid = 1; in_data = W'(8'hAA); in_last = 1; in_neg = 0; out_ready = 0;
    repeat (10) begin
      @(negedge clk);
      chk("stall_in_ready", AW'(in_ready), AW'(0));
      chk("stall_data", out_data, AW'(8'h55));
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("ready_after_take", AW'(in_ready), AW'(1));
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    chk("aa_accepted", AW'(in_ready), AW'(0));
    collect(AW'(8'hAA), "after_stall", 0);

    // reset during the third resolve cycle
    send(W'(8'h77), 0, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1; #1;
    chk("midrst_out_valid", AW'(out_valid), AW'(0));
    chk("midrst_in_ready", AW'(in_ready), AW'(1));
    @(negedge clk); rst = 0;
    send(W'(9), 0, 1);
    collect(AW'(9), "after_reset", 0);

    // randomized batches
    for (int b = 0; b < 40; b++) begin
      int len = $urandom_range(1, 6);
      exp = '0;
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        if ($urandom_range(0, 7) == 0) d = '1;
        neg = 1'($urandom_range(0, 1));
        exp = exp + opval(d, neg);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(d, neg, i == len - 1);
      end
      collect(exp, "random_batch", 1);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
